// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined RV32I control path.
package ctrl_pkg;

  localparam logic [6:0] OpcR     = 7'b0110011;
  localparam logic [6:0] OpcIAlu  = 7'b0010011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcBr    = 7'b1100011;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  typedef enum logic [3:0] {
    AluAdd   = 4'h0,
    AluSub   = 4'h1,
    AluAnd   = 4'h2,
    AluOr    = 4'h3,
    AluXor   = 4'h4,
    AluSlt   = 4'h5,
    AluSltu  = 4'h6,
    AluSll   = 4'h7,
    AluSrl   = 4'h8,
    AluSra   = 4'h9,
    AluPassB = 4'hA
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    ImmI = 3'b000,
    ImmS = 3'b001,
    ImmB = 3'b010,
    ImmJ = 3'b011,
    ImmU = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    PcPlus4  = 2'b00,
    PcTarget = 2'b01,
    PcAlu    = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    alu_ctrl_t   alu_control;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
    logic        illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational D-stage decode: main decode plus ALU decode, parameter-gated.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter bit FULL_BRANCH = 1'b1,
  parameter bit SHIFT_EN    = 1'b1
) (
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  output ctrl_bundle_t bundle,
  output imm_src_t     imm_src
);

  alu_ctrl_t alu_op;
  logic      shift_bad;
  logic      bad;

  // funct7_5 selects SUB only for R-type; it always selects SRA/SRAI.
  always_comb begin
    alu_op    = AluAdd;
    shift_bad = 1'b0;
    case (funct3)
      3'b000: alu_op = (op == OpcR && funct7_5) ? AluSub : AluAdd;
      3'b001: begin
        alu_op    = AluSll;
        shift_bad = !SHIFT_EN;
      end
      3'b010: alu_op = AluSlt;
      3'b011: alu_op = AluSltu;
      3'b100: alu_op = AluXor;
      3'b101: begin
        alu_op    = funct7_5 ? AluSra : AluSrl;
        shift_bad = !SHIFT_EN;
      end
      3'b110: alu_op = AluOr;
      default: alu_op = AluAnd;
    endcase
  end

  always_comb begin
    bundle        = BUBBLE;
    bundle.funct3 = funct3;
    imm_src       = ImmI;
    bad           = 1'b0;
    case (op)
      OpcR, OpcIAlu: begin
        bundle.reg_write   = 1'b1;
        bundle.alu_control = alu_op;
        bundle.alu_src     = (op == OpcIAlu);
        bad                = shift_bad;
      end
      OpcLoad: begin
        bundle.reg_write  = 1'b1;
        bundle.result_src = ResMem;
        bundle.alu_src    = 1'b1;
        bad               = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OpcStore: begin
        bundle.mem_write = 1'b1;
        bundle.alu_src   = 1'b1;
        imm_src          = ImmS;
        bad              = (funct3[2] || funct3 == 3'b011);
      end
      OpcBr: begin
        bundle.branch      = 1'b1;
        bundle.alu_control = AluSub;
        imm_src            = ImmB;
        bad                = (funct3[2:1] == 2'b01) || (funct3[2] && !FULL_BRANCH);
      end
      OpcJal: begin
        bundle.reg_write  = 1'b1;
        bundle.result_src = ResPc4;
        bundle.jump       = 1'b1;
        imm_src           = ImmJ;
      end
      OpcJalr: begin
        bundle.reg_write  = 1'b1;
        bundle.result_src = ResPc4;
        bundle.alu_src    = 1'b1;
        bundle.jalr       = 1'b1;
        bad               = (funct3 != 3'b000);
      end
      OpcLui: begin
        bundle.reg_write   = 1'b1;
        bundle.alu_src     = 1'b1;
        bundle.alu_control = AluPassB;
        imm_src            = ImmU;
      end
      OpcAuipc: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        imm_src          = ImmU;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      bundle         = BUBBLE;
      bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control path: D decode, E/M/W control registers and E-stage branch resolution.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter bit FULL_BRANCH = 1'b1,
  parameter bit SHIFT_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_d,
  input  logic [2:0] funct3_d,
  input  logic       funct7_5_d,
  input  logic       flush_e_i,
  input  logic       zero_e,
  input  logic       neg_e,
  input  logic       carry_e,
  input  logic       ovf_e,
  output logic [2:0] imm_src_d,
  output logic       alu_src_e,
  output logic [3:0] alu_control_e,
  output logic [1:0] pc_src_e,
  output logic [1:0] result_src_e,
  output logic       flush_d_o,
  output logic       reg_write_m,
  output logic       mem_write_m,
  output logic       reg_write_w,
  output logic [1:0] result_src_w,
  output logic       illegal_e
);

  ctrl_bundle_t dec_bundle;
  imm_src_t     dec_imm;
  ctrl_bundle_t e_d, e_q;
  logic         reg_write_m_q, mem_write_m_q;
  result_src_t  result_src_m_q;
  logic         reg_write_w_q;
  result_src_t  result_src_w_q;
  logic         taken;
  pc_src_t      pc_src;

  ctrl_decoder #(
    .FULL_BRANCH(FULL_BRANCH),
    .SHIFT_EN   (SHIFT_EN)
  ) u_decoder (
    .op      (op_d),
    .funct3  (funct3_d),
    .funct7_5(funct7_5_d),
    .bundle  (dec_bundle),
    .imm_src (dec_imm)
  );

  // carry_e=1 means no borrow, i.e. rs1 >=u rs2.
  always_comb begin
    taken = 1'b0;
    case (e_q.funct3)
      3'b000:  taken = zero_e;
      3'b001:  taken = !zero_e;
      3'b100:  taken = neg_e ^ ovf_e;
      3'b101:  taken = !(neg_e ^ ovf_e);
      3'b110:  taken = !carry_e;
      3'b111:  taken = carry_e;
      default: taken = 1'b0;
    endcase
    pc_src = PcPlus4;
    if (e_q.jalr) begin
      pc_src = PcAlu;
    end else if ((e_q.branch && taken) || e_q.jump) begin
      pc_src = PcTarget;
    end
  end

  always_comb begin
    e_d = dec_bundle;
    if (flush_e_i || flush_d_o) begin
      e_d = BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q            <= BUBBLE;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= ResAlu;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= ResAlu;
    end else begin
      e_q            <= e_d;
      reg_write_m_q  <= e_q.reg_write;
      mem_write_m_q  <= e_q.mem_write;
      result_src_m_q <= e_q.result_src;
      reg_write_w_q  <= reg_write_m_q;
      result_src_w_q <= result_src_m_q;
    end
  end

  assign imm_src_d     = dec_imm;
  assign alu_src_e     = e_q.alu_src;
  assign alu_control_e = e_q.alu_control;
  assign pc_src_e      = pc_src;
  assign result_src_e  = e_q.result_src;
  assign flush_d_o     = (pc_src != PcPlus4);
  assign illegal_e     = e_q.illegal;
  assign reg_write_m   = reg_write_m_q;
  assign mem_write_m   = mem_write_m_q;
  assign reg_write_w   = reg_write_w_q;
  assign result_src_w  = result_src_w_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_pipelined_control_unit;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpBad   = 7'b1111111;

  localparam int SigAluCtl = 0, SigAluSrc = 1, SigPc = 2, SigFlushD = 3, SigResE = 4;
  localparam int SigIll = 5, SigRegWM = 6, SigMemWM = 7, SigRegWW = 8, SigResW = 9;
  localparam int SigImm = 10, SigIllNb = 11, SigPcNb = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_d;
  logic [2:0] funct3_d;
  logic       funct7_5_d, flush_e_i, zero_e, neg_e, carry_e, ovf_e;
  logic [2:0] imm_src_d, imm_src_nb;
  logic       alu_src_e, alu_src_nb;
  logic [3:0] alu_control_e, alu_control_nb;
  logic [1:0] pc_src_e, pc_src_nb, result_src_e, result_src_e_nb, result_src_w, result_src_w_nb;
  logic       flush_d_o, flush_d_nb, reg_write_m, reg_write_m_nb, mem_write_m, mem_write_m_nb;
  logic       reg_write_w, reg_write_w_nb, illegal_e, illegal_nb;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pipelined_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .funct3_d(funct3_d), .funct7_5_d(funct7_5_d),
    .flush_e_i(flush_e_i), .zero_e(zero_e), .neg_e(neg_e), .carry_e(carry_e), .ovf_e(ovf_e),
    .imm_src_d(imm_src_d), .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
    .pc_src_e(pc_src_e), .result_src_e(result_src_e), .flush_d_o(flush_d_o),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .reg_write_w(reg_write_w),
    .result_src_w(result_src_w), .illegal_e(illegal_e)
  );

  // Reduced configuration: only BEQ/BNE and no shifts.
  pipelined_control_unit #(.FULL_BRANCH(1'b0), .SHIFT_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .funct3_d(funct3_d), .funct7_5_d(funct7_5_d),
    .flush_e_i(flush_e_i), .zero_e(zero_e), .neg_e(neg_e), .carry_e(carry_e), .ovf_e(ovf_e),
    .imm_src_d(imm_src_nb), .alu_src_e(alu_src_nb), .alu_control_e(alu_control_nb),
    .pc_src_e(pc_src_nb), .result_src_e(result_src_e_nb), .flush_d_o(flush_d_nb),
    .reg_write_m(reg_write_m_nb), .mem_write_m(mem_write_m_nb), .reg_write_w(reg_write_w_nb),
    .result_src_w(result_src_w_nb), .illegal_e(illegal_nb)
  );

  function automatic int actual(input int sig);
    case (sig)
      SigAluCtl: return int'(alu_control_e);
      SigAluSrc: return int'(alu_src_e);
      SigPc:     return int'(pc_src_e);
      SigFlushD: return int'(flush_d_o);
      SigResE:   return int'(result_src_e);
      SigIll:    return int'(illegal_e);
      SigRegWM:  return int'(reg_write_m);
      SigMemWM:  return int'(mem_write_m);
      SigRegWW:  return int'(reg_write_w);
      SigResW:   return int'(result_src_w);
      SigImm:    return int'(imm_src_d);
      SigIllNb:  return int'(illegal_nb);
      default:   return int'(pc_src_nb);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_at(input int c, input int sig, input int val, input string name);
    exp_t e;
    e.cyc  = c;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          check(sb[i].name, actual(sb[i].sig), sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive D instruction and the flags for whatever currently sits in E.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic fl, input logic z, input logic ng, input logic c,
                       input logic v);
    op_d       = op;
    funct3_d   = f3;
    funct7_5_d = f7;
    flush_e_i  = fl;
    zero_e     = z;
    neg_e      = ng;
    carry_e    = c;
    ovf_e      = v;
    n          = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu"}, int'(alu_control_e), 0);
    check({tag, "_pc"}, int'(pc_src_e), 0);
    check({tag, "_flush_d"}, int'(flush_d_o), 0);
    check({tag, "_regw_m"}, int'(reg_write_m), 0);
    check({tag, "_memw_m"}, int'(mem_write_m), 0);
    check({tag, "_regw_w"}, int'(reg_write_w), 0);
    check({tag, "_res_w"}, int'(result_src_w), 0);
    check({tag, "_ill"}, int'(illegal_e), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all_zero("reset_init");
    tick();
    tick();
    rst_n = 1'b1;

    issue(OpR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigAluCtl, 0, "add_alu");
    expect_at(n + 1, SigAluSrc, 0, "add_alu_src");
    expect_at(n + 3, SigRegWW, 1, "add_regw_w");
    tick();
    issue(OpR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigAluCtl, 1, "sub_alu");
    tick();
    issue(OpR, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigAluCtl, 9, "sra_alu");
    expect_at(n + 1, SigIllNb, 1, "sra_noshift_ill");
    tick();
    issue(OpI, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n, SigImm, 0, "addi_imm");
    expect_at(n + 1, SigAluCtl, 0, "addi_alu");
    expect_at(n + 1, SigAluSrc, 1, "addi_alu_src");
    tick();

    issue(OpBr, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n, SigImm, 2, "blt_imm");
    expect_at(n + 1, SigPc, 1, "blt_taken_pc");
    expect_at(n + 1, SigFlushD, 1, "blt_taken_flush");
    expect_at(n + 1, SigIllNb, 1, "blt_nb_ill");
    expect_at(n + 1, SigPcNb, 0, "blt_nb_pc");
    tick();
    issue(OpR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_at(n + 1, SigAluCtl, 0, "bubble_alu");
    expect_at(n + 1, SigPc, 0, "bubble_pc");
    expect_at(n + 2, SigRegWM, 0, "bubble_regw_m");
    expect_at(n + 3, SigRegWW, 0, "bubble_regw_w");
    tick();
    issue(OpBr, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigPc, 0, "blt_nt_pc");
    expect_at(n + 1, SigFlushD, 0, "blt_nt_flush");
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_at(n + 3, SigRegWW, 1, "after_nt_regw_w");
    tick();

    issue(OpBr, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigPc, 1, "bgeu_pc");
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    issue(OpJalr, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigPc, 2, "jalr_pc");
    expect_at(n + 3, SigResW, 2, "jalr_res_w");
    expect_at(n + 3, SigRegWW, 1, "jalr_regw_w");
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    issue(OpBr, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigPc, 1, "beq_pc");
    tick();
    issue(OpR, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigAluCtl, 0, "dbl_flush_alu");
    expect_at(n + 2, SigRegWM, 0, "dbl_flush_regw_m");
    tick();
    issue(OpR, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigAluCtl, 1, "post_flush_alu");
    expect_at(n + 1, SigPc, 0, "post_flush_pc");
    expect_at(n + 3, SigRegWW, 1, "post_flush_regw_w");
    tick();

    issue(OpLoad, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigResE, 1, "lw_res_e");
    expect_at(n + 1, SigAluSrc, 1, "lw_alu_src");
    expect_at(n + 3, SigResW, 1, "lw_res_w");
    expect_at(n + 3, SigRegWW, 1, "lw_regw_w");
    tick();
    issue(OpStore, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n, SigImm, 1, "sw_imm");
    expect_at(n + 2, SigMemWM, 1, "sw_memw_m");
    expect_at(n + 2, SigRegWM, 0, "sw_regw_m");
    expect_at(n + 3, SigMemWM, 0, "sw_memw_m_next");
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    issue(OpLui, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n, SigImm, 4, "lui_imm");
    expect_at(n + 1, SigAluCtl, 10, "lui_alu");
    tick();
    issue(OpJal, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n, SigImm, 3, "jal_imm");
    expect_at(n + 1, SigPc, 1, "jal_pc");
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    issue(OpBad, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_at(n + 1, SigIll, 1, "illegal_e");
    expect_at(n + 1, SigPc, 0, "illegal_pc");
    expect_at(n + 2, SigIll, 0, "illegal_one_cycle");
    expect_at(n + 2, SigRegWM, 0, "illegal_regw_m");
    expect_at(n + 3, SigRegWW, 0, "illegal_regw_w");
    expect_at(n + 3, SigMemWM, 0, "illegal_memw_m");
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Store reaches M, then reset arrives mid-cycle.
    issue(OpStore, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    issue(OpI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_pre_memw_m", int'(mem_write_m), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    tick();
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    tick();
    tick();

    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        errors++;
        $display("FAIL %s: never checked, expected %0d at cycle %0d", sb[i].name, sb[i].val,
                 sb[i].cyc);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised, pipelined RISC-V RV32I control unit for the five-stage core. It decodes in D, carries control bundles through E/M/W pipeline registers and resolves all six branch conditions plus JAL/JALR in E from ALU flags. It also generates bubbles on hazard-unit flush and on taken control transfers. It replaces the single-cycle control path; datapath registers stay in the datapath.

## Interface
- FULL_BRANCH, 1, 1: BEQ/BNE/BLT/BGE/BLTU/BGEU supported; 0: only BEQ/BNE, others illegal
- SHIFT_EN, 1, 1: SLL/SRL/SRA(+I) decoded; 0: decoded as illegal

- clk  in  1  clock, all registers on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_d  in  7  opcode of instruction in D
- funct3_d  in  3  funct3 in D
- funct7_5_d  in  1  instr[30] in D
- flush_e_i  in  1  hazard-unit request: load bubble into E next edge
- zero_e, neg_e, carry_e, ovf_e  in  1 each  flags of E-stage ALU result; carry_e=1 means no borrow (rs1 ≥u rs2)
- imm_src_d  out  3  combinational: 000 I, 001 S, 010 B, 011 J, 100 U
- alu_src_e  out  1  0 rs2, 1 imm
- alu_control_e  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, A pass-B
- pc_src_e  out  2  00 PC+4, 01 PC+imm (taken branch/JAL), 10 ALU result (JALR), 11 never driven
- result_src_e  out  2  for load-use detection
- flush_d_o  out  1  = (pc_src_e != 00)
- reg_write_m, mem_write_m  out  1 each
- reg_write_w  out  1; result_src_w  out  2  (00 ALU, 01 mem, 10 PC+4)
- illegal_e  out  1  E holds an undecodable instruction

## Operation
- D decode (combinational): opcodes R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. LUI → pass-B; AUIPC → add with PC operand (alu_src=1). I-type SUB does not exist: funct7_5 honoured only for R-type add/sub and SRAI/SRA.
- Illegal (unknown opcode, disabled branch/shift, bad funct3): bundle is bubble except illegal=1.
- E register loads the D bundle {reg_write, result_src, mem_write, alu_control, alu_src, branch, jump, jalr, funct3, illegal}; loads bubble (all zero) when flush_e_i or flush_d_o is 1; both at once → single bubble.
- Branch taken in E: funct3 000 zero; 001 !zero; 100 neg^ovf; 101 !(neg^ovf); 110 !carry; 111 carry. Branch taken or jump → 01; jalr → 10; else 00.
- M register copies {reg_write, result_src, mem_write} from E; W copies {reg_write, result_src} from M. M and W never stall or flush.

## Timing
- Reset: all pipeline registers zero; every registered output 0; pc_src_e=00, flush_d_o=0. Reset mid-operation discards in-flight stores/writes, no partial state survives.
- Latency: decoded in cycle n (D) → E outputs n+1 → M n+2 → W n+3.
- pc_src_e/flush_d_o combinational from E register and flags, same cycle; instruction in D during a taken cycle becomes a bubble in E next cycle.
- An illegal instruction asserts illegal_e exactly one cycle and produces no writes.

## Structure
- Package ctrl_pkg: opcode constants, alu_ctrl_t, imm_src_t, result_src_t, pc_src_t enums, ctrl_bundle_t struct, BUBBLE constant.
- Sub-module ctrl_decoder: combinational D decode (main + ALU decode, parameter-gated); top holds three register stages and branch resolution.

## Test plan
- Reset: assert rst_n=0 mid-stream with store in M → mem_write_m=0, all outputs 0 immediately.
- ADD/SUB/SRA R-type then ADDI → alu_control_e 0,1,9,0 one cycle after D; reg_write_w=1 three cycles after D.
- BLT with neg_e=1, ovf_e=0 → pc_src_e=01, flush_d_o=1, next E bundle all zero; same with ovf_e=1 → 00.
- BGEU carry_e=1 → 01; JALR → 10, result_src_w=10; FULL_BRANCH=0 with BLT → illegal_e=1, pc_src_e=00.
- flush_e_i=1 coincident with taken BEQ → exactly one bubble, following instruction decoded normally.
- LW → result_src_e=01 in E, result_src_w=01 and reg_write_w=1 at n+3; SW → mem_write_m=1 at n+2 only.
